// File: rtl/ndc_pixel_map_pkg.sv
// ndc_pixel_map_pkg: shared types and constants for the NDC -> pixel mapper.
//   - fp16 field constants (bias, mantissa width, all-ones exponent)
//   - f16_t / vec2_f16_t point types, ndc_class_t decode classes, pixel_t
//   - fp16_classify(): decode of one fp16 value into an ndc_class_t
package ndc_pixel_map_pkg;

    localparam int unsigned PIX_W_DEFAULT = 11;

    localparam int unsigned FP16_BIAS    = 15;
    localparam int unsigned FP16_MAN_W   = 10;
    localparam int unsigned FP16_EXP_MAX = 31;

    typedef logic [15:0] f16_t;
    typedef f16_t [1:0]  vec2_f16_t;  // [0]=x, [1]=y

    typedef enum logic [2:0] {ZERO, NORM, BIG, NEG, INF, NAN} ndc_class_t;

    typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

    // Priority matters: -inf and -NaN must land on the "0, clamped" side, so NAN/NEG are
    // tested before INF. Subnormals (e=0, m!=0) fold into ZERO.
    function automatic ndc_class_t fp16_classify(input f16_t v);
        logic                  s;
        logic [4:0]            e;
        logic [FP16_MAN_W-1:0] m;
        ndc_class_t            cls;
        s = v[15];
        e = v[14:FP16_MAN_W];
        m = v[FP16_MAN_W-1:0];
        if (e == 5'd0) begin
            cls = ZERO;
        end else if (e == 5'(FP16_EXP_MAX) && m != '0) begin
            cls = NAN;
        end else if (s) begin
            cls = NEG;
        end else if (e == 5'(FP16_EXP_MAX)) begin
            cls = INF;
        end else if (e >= 5'(FP16_BIAS)) begin
            cls = BIG;
        end else begin
            cls = NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ndc_pixel_map_if.sv
// ndc_pixel_map_if: point-in / pixel-out bus of ndc_pixel_map.
//   ndc_pt, canvas_width, canvas_height, input_valid / input_ready : point side
//   pixel_x, pixel_y, clamp_x, clamp_y, pixel_valid / pixel_ready  : pixel side
//   master modport = producer of points and consumer of pixels; slave = the mapper.
interface ndc_pixel_map_if
    import ndc_pixel_map_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEFAULT
);

    vec2_f16_t        ndc_pt;
    logic [PIX_W-1:0] canvas_width;
    logic [PIX_W-1:0] canvas_height;
    logic             input_valid;
    logic             input_ready;
    logic [PIX_W-1:0] pixel_x;
    logic [PIX_W-1:0] pixel_y;
    logic             clamp_x;
    logic             clamp_y;
    logic             pixel_valid;
    logic             pixel_ready;

    modport master (
        output ndc_pt, canvas_width, canvas_height, input_valid, pixel_ready,
        input  input_ready, pixel_x, pixel_y, clamp_x, clamp_y, pixel_valid
    );

    modport slave (
        input  ndc_pt, canvas_width, canvas_height, input_valid, pixel_ready,
        output input_ready, pixel_x, pixel_y, clamp_x, clamp_y, pixel_valid
    );

endinterface

// File: rtl/ndc_axis_to_pixel.sv
// ndc_axis_to_pixel: one axis of the NDC -> pixel mapper, three register stages
// (decode, multiply, scale/clamp). All stages advance together on adv_i; validity is
// tracked by the parent.
//   clk, rst : clock, async active-high reset
//   adv_i    : pipeline advance
//   ndc_i    : fp16 NDC coordinate
//   dim_i    : canvas dimension on this axis
//   pixel_o  : pixel coordinate, clamp_o : result was clamped
// Optional: define NDC_PIXEL_ROUND_EN for round-half-up instead of floor.
module ndc_axis_to_pixel
    import ndc_pixel_map_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  f16_t             ndc_i,
    input  logic [PIX_W-1:0] dim_i,
    output logic [PIX_W-1:0] pixel_o,
    output logic             clamp_o
);

    localparam int unsigned PROD_W = 11 + PIX_W;
    // Rounding adds up to 2^23 (smallest normal exponent), so leave room for that.
    localparam int unsigned SUM_W  = (PROD_W > 24) ? PROD_W + 1 : 25;
    // value = {1,m} * 2^(e - bias - man_w)
    localparam logic [4:0]  SHIFT_BASE = 5'(FP16_BIAS + FP16_MAN_W);

    // S1 decode
    logic [10:0]       sig1_d, sig1_q;
    logic [4:0]        exp1_d, exp1_q;
    ndc_class_t        cls1_d, cls1_q;
    logic [PIX_W-1:0]  dim1_d, dim1_q;
    // S2 multiply
    logic [PROD_W-1:0] prod2_d, prod2_q;
    logic [4:0]        exp2_d, exp2_q;
    ndc_class_t        cls2_d, cls2_q;
    logic [PIX_W-1:0]  dim2_d, dim2_q;
    // S3 scale/clamp
    logic [PIX_W-1:0]  pix3_d, pix3_q;
    logic              clamp3_d, clamp3_q;

    logic [4:0]        shamt;
    logic [SUM_W-1:0]  scaled;

    always_comb begin
        sig1_d   = sig1_q;
        exp1_d   = exp1_q;
        cls1_d   = cls1_q;
        dim1_d   = dim1_q;
        prod2_d  = prod2_q;
        exp2_d   = exp2_q;
        cls2_d   = cls2_q;
        dim2_d   = dim2_q;
        pix3_d   = pix3_q;
        clamp3_d = clamp3_q;

        // Only meaningful for NORM (e in 1..14 -> shift 11..24); other classes ignore it.
        shamt = SHIFT_BASE - exp2_q;
`ifdef NDC_PIXEL_ROUND_EN
        scaled = (SUM_W'(prod2_q) + (SUM_W'(1) << (shamt - 5'd1))) >> shamt;
`else
        scaled = SUM_W'(prod2_q) >> shamt;
`endif

        if (adv_i) begin
            sig1_d = {1'b1, ndc_i[FP16_MAN_W-1:0]};
            exp1_d = ndc_i[14:FP16_MAN_W];
            cls1_d = fp16_classify(ndc_i);
            dim1_d = dim_i;

            prod2_d = PROD_W'(sig1_q) * PROD_W'(dim1_q);
            exp2_d  = exp1_q;
            cls2_d  = cls1_q;
            dim2_d  = dim1_q;

            if (dim2_q == '0) begin
                pix3_d   = '0;
                clamp3_d = 1'b1;
            end else begin
                case (cls2_q)
                    ZERO: begin
                        pix3_d   = '0;
                        clamp3_d = 1'b0;
                    end
                    NEG, NAN: begin
                        pix3_d   = '0;
                        clamp3_d = 1'b1;
                    end
                    INF, BIG: begin
                        pix3_d   = dim2_q - 1'b1;
                        clamp3_d = 1'b1;
                    end
                    default: begin
                        if (scaled >= SUM_W'(dim2_q)) begin
                            pix3_d   = dim2_q - 1'b1;
                            clamp3_d = 1'b1;
                        end else begin
                            pix3_d   = scaled[PIX_W-1:0];
                            clamp3_d = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig1_q   <= '0;
            exp1_q   <= '0;
            cls1_q   <= ZERO;
            dim1_q   <= '0;
            prod2_q  <= '0;
            exp2_q   <= '0;
            cls2_q   <= ZERO;
            dim2_q   <= '0;
            pix3_q   <= '0;
            clamp3_q <= 1'b0;
        end else begin
            sig1_q   <= sig1_d;
            exp1_q   <= exp1_d;
            cls1_q   <= cls1_d;
            dim1_q   <= dim1_d;
            prod2_q  <= prod2_d;
            exp2_q   <= exp2_d;
            cls2_q   <= cls2_d;
            dim2_q   <= dim2_d;
            pix3_q   <= pix3_d;
            clamp3_q <= clamp3_d;
        end
    end

    assign pixel_o = pix3_q;
    assign clamp_o = clamp3_q;

endmodule

// File: rtl/ndc_pixel_map.sv
// ndc_pixel_map: maps an fp16 NDC point in [0,1]^2 to integer framebuffer coordinates,
// pixel = floor(ndc * dim) clamped to [0, dim-1]. 3-cycle latency, 1 point/cycle.
//   clk, rst : clock, async active-high reset (discards in-flight points)
//   bus      : ndc_pixel_map_if slave (point in with canvas size, pixel out, valid/ready)
// Optional: define NDC_PIXEL_ROUND_EN for round-half-up instead of floor.
module ndc_pixel_map
    import ndc_pixel_map_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    ndc_pixel_map_if.slave      bus
);

    logic adv;
    logic v1_d, v1_q;
    logic v2_d, v2_q;
    logic pv_d, pv_q;

    // Whole pipeline moves as one; it only stalls when the output slot is full and blocked.
    assign adv             = !pv_q || bus.pixel_ready;
    assign bus.input_ready = adv;
    assign bus.pixel_valid = pv_q;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        pv_d = pv_q;
        if (adv) begin
            v1_d = bus.input_valid;
            v2_d = v1_q;
            pv_d = v2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            pv_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            pv_q <= pv_d;
        end
    end

    ndc_axis_to_pixel #(
        .PIX_W (PIX_W)
    ) u_axis_x (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv),
        .ndc_i   (bus.ndc_pt[0]),
        .dim_i   (bus.canvas_width),
        .pixel_o (bus.pixel_x),
        .clamp_o (bus.clamp_x)
    );

    ndc_axis_to_pixel #(
        .PIX_W (PIX_W)
    ) u_axis_y (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv),
        .ndc_i   (bus.ndc_pt[1]),
        .dim_i   (bus.canvas_height),
        .pixel_o (bus.pixel_y),
        .clamp_o (bus.clamp_y)
    );

endmodule

// File: tb/tb_ndc_pixel_map.sv
// tb_ndc_pixel_map: directed, self-checking bench for ndc_pixel_map.
module tb_ndc_pixel_map;
    import ndc_pixel_map_pkg::*;

    localparam int unsigned PW = 11;
`ifdef NDC_PIXEL_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ndc_pixel_map_if #(.PIX_W(PW)) bus ();

    ndc_pixel_map #(
        .PIX_W (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One isolated point: checks 3-cycle latency, both axes, and single emission.
    task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [10:0] w, input logic [10:0] h,
                          input int ex, input int ey, input int ecx, input int ecy);
        int n;
        @(negedge clk);
        bus.ndc_pt[0]     = x;
        bus.ndc_pt[1]     = y;
        bus.canvas_width  = w;
        bus.canvas_height = h;
        bus.input_valid   = 1'b1;
        #1;
        check_eq({tag, "_in_rdy"}, 32'(bus.input_ready), 32'd1);
        @(posedge clk);
        n = 1;
        #1;
        bus.input_valid = 1'b0;
        while (!bus.pixel_valid && n < 10) begin
            @(posedge clk);
            n++;
            #1;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'd3);
        check_eq({tag, "_px"}, 32'(bus.pixel_x), 32'(ex));
        check_eq({tag, "_py"}, 32'(bus.pixel_y), 32'(ey));
        check_eq({tag, "_cx"}, 32'(bus.clamp_x), 32'(ecx));
        check_eq({tag, "_cy"}, 32'(bus.clamp_y), 32'(ecy));
        @(posedge clk);
        #1;
        check_eq({tag, "_once"}, 32'(bus.pixel_valid), 32'd0);
    endtask

    logic [15:0] str_ndc [8] = '{16'h3800, 16'h3400, 16'h3A00, 16'h3000,
                                 16'h3600, 16'h3200, 16'h2C00, 16'h3B00};
    int          str_ex  [8] = '{320, 160, 480, 80, 240, 120, 40, 560};
    int          str_ey  [8] = '{240, 120, 360, 60, 180, 90, 30, 420};

    initial begin
        int sent;
        int got;
        int seen;
        bit stall;

        rst               = 1'b1;
        bus.ndc_pt[0]     = '0;
        bus.ndc_pt[1]     = '0;
        bus.canvas_width  = 11'd640;
        bus.canvas_height = 11'd480;
        bus.input_valid   = 1'b0;
        bus.pixel_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(bus.pixel_valid), 32'd0);
        check_eq("rst_px", 32'(bus.pixel_x), 32'd0);
        check_eq("rst_py", 32'(bus.pixel_y), 32'd0);
        check_eq("rst_cx", 32'(bus.clamp_x), 32'd0);
        check_eq("rst_cy", 32'(bus.clamp_y), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        single("basic", 16'h3800, 16'h3400, 11'd640, 11'd480, 320, 120, 0, 0);
        single("one_inf", 16'h3C00, 16'h7C00, 11'd640, 11'd480, 639, 479, 1, 1);
        single("nan_neg", 16'h7E00, 16'hB800, 11'd640, 11'd480, 0, 0, 1, 1);
        single("nz_sub", 16'h8000, 16'h0001, 11'd640, 11'd480, 0, 0, 0, 0);
        single("near1", 16'h3BFF, 16'h3BFF, 11'd640, 11'd480, 639, 479,
               int'(RoundEn), int'(RoundEn));
        single("mixed", 16'h3555, 16'h3E00, 11'd640, 11'd480, 213, 479, 0, 1);
        single("tiny_ninf", 16'h0400, 16'hFC00, 11'd2047, 11'd480, 0, 0, 0, 1);
        single("dim_edge", 16'h3800, 16'h3BFF, 11'd0, 11'd2047, 0, 2046, 1, 0);

        // Back-to-back stream with a 5-cycle output stall in the middle.
        sent = 0;
        got  = 0;
        bus.canvas_width  = 11'd640;
        bus.canvas_height = 11'd480;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            stall           = (cyc >= 4 && cyc < 9);
            bus.pixel_ready = !stall;
            bus.input_valid = (sent < 8);
            if (sent < 8) begin
                bus.ndc_pt[0] = str_ndc[sent];
                bus.ndc_pt[1] = str_ndc[sent];
            end
            #1;
            if (stall && bus.pixel_valid) begin
                check_eq("stall_in_rdy", 32'(bus.input_ready), 32'd0);
            end
            if (bus.pixel_valid && bus.pixel_ready) begin
                check_eq("str_px", 32'(bus.pixel_x), 32'(str_ex[got]));
                check_eq("str_py", 32'(bus.pixel_y), 32'(str_ey[got]));
                got++;
            end
            if (bus.input_valid && bus.input_ready) begin
                sent++;
            end
        end
        bus.input_valid = 1'b0;
        bus.pixel_ready = 1'b1;
        check_eq("str_count", 32'(got), 32'd8);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.pixel_valid) seen++;
        end
        check_eq("str_no_extra", 32'(seen), 32'd0);

        // Reset with three points in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ndc_pt[0]   = 16'h3800;
            bus.ndc_pt[1]   = 16'h3400;
            bus.input_valid = 1'b1;
            @(posedge clk);
        end
        #2;
        check_eq("pre_rst_valid", 32'(bus.pixel_valid), 32'd1);
        rst = 1'b1;
        #1;
        bus.input_valid = 1'b0;
        check_eq("mid_rst_valid", 32'(bus.pixel_valid), 32'd0);
        check_eq("mid_rst_px", 32'(bus.pixel_x), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.pixel_valid) seen++;
        end
        check_eq("post_rst_none", 32'(seen), 32'd0);
        single("post_rst", 16'h3800, 16'h3400, 11'd640, 11'd480, 320, 120, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ndc_pixel_map.md
Name: ndc_pixel_map

Overview:
- Inverse of the screen-to-NDC vertex stage. Takes an fp16 NDC point in [0,1] per axis and produces integer framebuffer pixel coordinates, pixel = floor(ndc * dimension), clamped to [0, dim-1].
- Sits between the vertex/NDC pipeline and the rasterizer/framebuffer address generator.
- Fully pipelined, in-house fp16 decode (no vendor float IP), valid/ready on both sides.

Parameters:
- PIX_W, 11, width of the canvas dimensions and the pixel outputs (max dimension 2^PIX_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ndc_pt  in  vec2_f16  [0]=x, [1]=y, fp16 NDC
- canvas_width  in  PIX_W  unsigned, sampled with the point
- canvas_height  in  PIX_W  unsigned, sampled with the point
- input_valid  in  1  point valid
- input_ready  out  1  point accepted when input_valid && input_ready
- pixel_x  out  PIX_W  pixel column
- pixel_y  out  PIX_W  pixel row
- clamp_x  out  1  x was out of range or invalid and has been clamped
- clamp_y  out  1  y was out of range or invalid and has been clamped
- pixel_valid  out  1  output valid
- pixel_ready  in  1  downstream accept

Behaviour:
- Reset: pixel_x, pixel_y, clamp_x, clamp_y, pixel_valid and all internal stage valids are 0 immediately (async). Reset mid-stream discards all in-flight points.
- Latency: 3 cycles from accept to pixel_valid. Throughput: 1 point/cycle.
- Stall rule: adv = !pixel_valid || pixel_ready; input_ready = adv (combinational). When adv=0, all stages hold. No drops, no duplicates, order preserved.
- S1 (decode):
  - Split into sign s, exponent e[4:0], mantissa m[9:0]; S = {1,m} (11b).
  - Class:
    - ZERO: e=0, either sign; subnormals are also treated as ZERO.
    - NAN: e=31, m≠0.
    - INF: e=31, m=0.
    - NEG: s=1, not ZERO.
    - BIG: e≥15, i.e. ndc≥1.0.
    - NORM: otherwise.
  - Register S, e, class and the dimension.
- S2 (multiply): P = S * dim, width 11+PIX_W, unsigned.
- S3 (scale/clamp): for NORM, pixel = P >> (25-e); any shift ≥ 11+PIX_W gives 0. Then:
  - pixel ≥ dim: pixel = dim-1, clamp=1.
  - ZERO: 0, clamp=0.
  - NEG or NAN: 0, clamp=1.
  - INF or BIG: dim-1, clamp=1.
  - dim=0: pixel 0, clamp=1.
- Axes are independent. pixel_valid is common to both axes.
- Output registers update only on adv.

Optional Feature:
- Macro: NDC_PIXEL_ROUND_EN.
- Defined: NORM result is round-half-up, floor((P + 2^(24-e)) >> (25-e)), before clamping, so ndc*dim ≥ dim-0.5 clamps to dim-1 with clamp=1.
- Undefined: pure floor as specified above. Latency is unchanged in both cases.

Decomposition:
- Package types adds:
  - FP16_BIAS=15, FP16_MAN_W=10, FP16_EXP_MAX=31.
  - typedef enum ndc_class_t {ZERO, NORM, BIG, NEG, INF, NAN}.
  - typedef pixel_t logic [PIX_W-1:0], with PIX_W default constant.
- One sub-module, ndc_axis_to_pixel: one axis, all 3 stages, shared adv input. Instantiated twice; the top owns the handshake.

Test Plan:
- W=640, H=480, ndc (0x3800=0.5, 0x3400=0.25), pixel_ready=1 -> (320,120), clamp 0/0, pixel_valid exactly 3 cycles after accept.
- x=0x3C00 (1.0), y=0x7C00 (+inf), W=640, H=480 -> (639,479), clamp 1/1. x=0x7E00 (NaN), y=0xB800 (-0.5) -> (0,0), clamp 1/1. x=0x8000 (-0) -> 0, clamp_x 0.
- x=0x3BFF (0.99951), W=640 -> 639, clamp 0 without the macro; 639, clamp 1 with NDC_PIXEL_ROUND_EN. x=0x0001 (subnormal) -> 0, clamp 0.
- Stream 8 back-to-back points, pixel_ready low for 5 cycles mid-stream -> input_ready low while stalled, all 8 outputs in order, none lost or repeated.
- Assert rst during 3 in-flight points -> pixel_valid=0 immediately, none emitted after release. The next point after release is output with 3-cycle latency.
- W=0, x=0x3800 -> pixel_x 0, clamp_x 1. W=2047, x=0x3BFF -> 2046, clamp 0 (floor).
